btb_sa: RTL and testbench

- Parametrised set-associative branch target buffer; successor to the direct-mapped, valid+target-only BTB.
- Adds per-entry tag compare, a per-entry saturating direction counter, multi-way sets with round-robin replacement, and a synchronous flush.
- Fetch stage reads it combinationally: hit, predicted direction and target for the current PC.
- Execute stage updates it with the resolved outcome of each branch/jump.

---
 rtl/btb_sa.sv | 190 +++++++++++++++++++
 tb/tb_btb_sa.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/btb_sa.sv
// Set-associative branch target buffer.
// Fetch looks up the current PC combinationally (hit / direction / target).
// Execute writes back resolved branches: hits train the direction counter
// and refresh the target, taken misses allocate a way using an
// invalid-first, then round-robin, victim choice.
module btb_sa #(
  parameter int PC_W  = 16,
  parameter int IDX_W = 8,
  parameter int WAYS  = 2,
  parameter int CTR_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_flush,
  input  logic [PC_W-1:0] i_rd_pc,
  output logic            o_hit,
  output logic            o_taken,
  output logic [PC_W-1:0] o_target,
  input  logic            i_upd,
  input  logic [PC_W-1:0] i_upd_pc,
  input  logic            i_upd_taken,
  input  logic [PC_W-1:0] i_upd_target
);

  localparam int SETS  = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W;
  // A single-way build still carries a 1-bit pointer; it is held at zero.
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_MIN  = '0;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

  // Address split for both lookup ports
  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;

  assign rd_idx  = i_rd_pc[IDX_W-1:0];
  assign rd_tag  = i_rd_pc[PC_W-1:IDX_W];
  assign upd_idx = i_upd_pc[IDX_W-1:0];
  assign upd_tag = i_upd_pc[PC_W-1:IDX_W];

  // Per-way views of the addressed set, one for fetch and one for update
  logic             rd_valid  [WAYS];
  logic [TAG_W-1:0] rd_tagv   [WAYS];
  logic [PC_W-1:0]  rd_tgt    [WAYS];
  logic [CTR_W-1:0] rd_ctr    [WAYS];
  logic             upd_valid [WAYS];
  logic [TAG_W-1:0] upd_tagv  [WAYS];
  logic [PC_W-1:0]  upd_tgt   [WAYS];
  logic [CTR_W-1:0] upd_ctr   [WAYS];

  // Write controls produced by the update logic
  logic [WAYS-1:0]  way_we;
  logic [PC_W-1:0]  wr_target_d;
  logic [CTR_W-1:0] wr_ctr_d;

  // Round-robin victim pointer per set
  logic [PTR_W-1:0] ptr_q [SETS];
  logic [PTR_W-1:0] ptr_d;
  logic             ptr_we;

  // Entry storage, one bank per way
  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    logic             valid_q  [SETS];
    logic [TAG_W-1:0] tag_q    [SETS];
    logic [PC_W-1:0]  target_q [SETS];
    logic [CTR_W-1:0] ctr_q    [SETS];

    assign rd_valid[gi]  = valid_q[rd_idx];
    assign rd_tagv[gi]   = tag_q[rd_idx];
    assign rd_tgt[gi]    = target_q[rd_idx];
    assign rd_ctr[gi]    = ctr_q[rd_idx];
    assign upd_valid[gi] = valid_q[upd_idx];
    assign upd_tagv[gi]  = tag_q[upd_idx];
    assign upd_tgt[gi]   = target_q[upd_idx];
    assign upd_ctr[gi]   = ctr_q[upd_idx];

    // Entry write: reset clears everything, flush only drops valid bits
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[s]  <= 1'b0;
          tag_q[s]    <= '0;
          target_q[s] <= '0;
          ctr_q[s]    <= '0;
        end
      end else if (i_flush) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[s] <= 1'b0;
        end
      end else if (way_we[gi]) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= wr_target_d;
        ctr_q[upd_idx]    <= wr_ctr_d;
      end
    end
  end

  // Fetch lookup: lowest-numbered matching way wins, misses read as zero
  logic [PTR_W-1:0] rd_way;
  always_comb begin
    o_hit  = 1'b0;
    rd_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (rd_valid[w] && (rd_tagv[w] == rd_tag)) begin
        o_hit  = 1'b1;
        rd_way = PTR_W'(w);
      end
    end
    o_taken  = o_hit & rd_ctr[rd_way][CTR_W-1];
    o_target = o_hit ? rd_tgt[rd_way] : '0;
  end

  // Update-side tag match and victim search
  logic             upd_hit;
  logic [PTR_W-1:0] upd_way;
  logic             any_inv;
  logic [PTR_W-1:0] inv_way;
  logic [PTR_W-1:0] victim;
  always_comb begin
    upd_hit = 1'b0;
    upd_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (upd_valid[w] && (upd_tagv[w] == upd_tag)) begin
        upd_hit = 1'b1;
        upd_way = PTR_W'(w);
      end
      if (!upd_valid[w]) begin
        any_inv = 1'b1;
        inv_way = PTR_W'(w);
      end
    end
    victim = any_inv ? inv_way : ptr_q[upd_idx];
  end

  // New entry contents and write enables for the resolved branch
  logic             do_upd;
  logic             do_alloc;
  logic [CTR_W-1:0] cur_ctr;
  always_comb begin
    do_upd   = i_upd & ~i_flush;
    do_alloc = do_upd & ~upd_hit & i_upd_taken;
    cur_ctr  = upd_ctr[upd_way];

    // Hits train the saturating counter; allocations start weakly taken
    wr_ctr_d = CTR_WEAK;
    if (upd_hit) begin
      if (i_upd_taken) begin
        wr_ctr_d = (cur_ctr == CTR_MAX) ? cur_ctr : cur_ctr + 1'b1;
      end else begin
        wr_ctr_d = (cur_ctr == CTR_MIN) ? cur_ctr : cur_ctr - 1'b1;
      end
    end

    // A not-taken hit keeps the old target; everything else takes the new one
    wr_target_d = (upd_hit && !i_upd_taken) ? upd_tgt[upd_way] : i_upd_target;

    way_we = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_we[w] = (do_upd & upd_hit & (upd_way == PTR_W'(w))) |
                  (do_alloc & (victim == PTR_W'(w)));
    end

    // The pointer only moves when it actually supplied the victim
    ptr_we = do_alloc & ~any_inv;
    ptr_d  = (WAYS == 1) ? '0 : PTR_W'(victim + 1'b1);
  end

  // Victim pointer register: cleared by reset and by flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        ptr_q[s] <= '0;
      end
    end else if (i_flush) begin
      for (int s = 0; s < SETS; s++) begin
        ptr_q[s] <= '0;
      end
    end else if (ptr_we) begin
      ptr_q[upd_idx] <= ptr_d;
    end
  end

endmodule

// File: tb/tb_btb_sa.sv
// Bench for btb_sa: directed walk through the expected behaviours, then a
// randomized run against a behavioural model of the sets.
module tb_btb_sa;
  localparam int PC_W  = 16;
  localparam int IDX_W = 8;
  localparam int WAYS  = 2;
  localparam int CTR_W = 2;
  localparam int SETS  = 1 << IDX_W;
  localparam int CMAX  = (1 << CTR_W) - 1;

  logic            clk;
  logic            reset;
  logic            i_flush;
  logic [PC_W-1:0] i_rd_pc;
  logic            o_hit;
  logic            o_taken;
  logic [PC_W-1:0] o_target;
  logic            i_upd;
  logic [PC_W-1:0] i_upd_pc;
  logic            i_upd_taken;
  logic [PC_W-1:0] i_upd_target;

  btb_sa #(.PC_W(PC_W), .IDX_W(IDX_W), .WAYS(WAYS), .CTR_W(CTR_W)) dut (
    .clk(clk), .reset(reset), .i_flush(i_flush), .i_rd_pc(i_rd_pc),
    .o_hit(o_hit), .o_taken(o_taken), .o_target(o_target),
    .i_upd(i_upd), .i_upd_pc(i_upd_pc), .i_upd_taken(i_upd_taken),
    .i_upd_target(i_upd_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model: each slot remembers the full PC that allocated it
  bit m_valid [SETS][WAYS];
  int m_pc    [SETS][WAYS];
  int m_tgt   [SETS][WAYS];
  int m_ctr   [SETS][WAYS];
  int m_ptr   [SETS];

  function automatic void m_reset();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0; m_pc[s][w] = 0; m_tgt[s][w] = 0; m_ctr[s][w] = 0;
      end
    end
  endfunction

  function automatic int m_find(input int pc);
    int s = pc % SETS;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && (m_pc[s][w] / SETS) == (pc / SETS)) return w;
    return -1;
  endfunction

  function automatic void m_apply(input bit u, input int pc, input bit tk,
                                  input int tgt, input bit fl);
    int s = pc % SETS;
    int w;
    if (fl) begin
      for (int a = 0; a < SETS; a++) begin
        m_ptr[a] = 0;
        for (int b = 0; b < WAYS; b++) m_valid[a][b] = 0;
      end
      return;
    end
    if (!u) return;
    w = m_find(pc);
    if (w >= 0) begin
      if (tk) begin
        if (m_ctr[s][w] < CMAX) m_ctr[s][w]++;
        m_tgt[s][w] = tgt;
      end else if (m_ctr[s][w] > 0) begin
        m_ctr[s][w]--;
      end
    end else if (tk) begin
      w = -1;
      for (int b = WAYS - 1; b >= 0; b--) if (!m_valid[s][b]) w = b;
      if (w < 0) begin
        w = m_ptr[s];
        m_ptr[s] = (m_ptr[s] + 1) % WAYS;
      end
      m_valid[s][w] = 1; m_pc[s][w] = pc; m_tgt[s][w] = tgt;
      m_ctr[s][w] = 1 << (CTR_W - 1);
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  // Compare the fetch outputs for the current i_rd_pc against the model
  task automatic chk_model(input string nm);
    int w = m_find(int'(i_rd_pc));
    int s = int'(i_rd_pc) % SETS;
    bit eh = (w >= 0);
    bit et = eh ? m_ctr[s][w] >= (1 << (CTR_W - 1)) : 1'b0;
    logic [31:0] etg = eh ? 32'(m_tgt[s][w]) : 32'h0;
    chk({nm, "_hit"}, 32'(o_hit), 32'(eh));
    chk({nm, "_taken"}, 32'(o_taken), 32'(et));
    chk({nm, "_target"}, 32'(o_target), etg);
    $display("rd pc=%04h hit=%0b taken=%0b target=%04h", i_rd_pc, o_hit, o_taken, o_target);
  endtask

  // One clock: drive read + update, check read before the edge, advance model
  task automatic cycle(input logic [15:0] rpc, input logic u, input logic [15:0] upc,
                       input logic tk, input logic [15:0] tgt, input logic fl);
    i_rd_pc = rpc; i_upd = u; i_upd_pc = upc; i_upd_taken = tk;
    i_upd_target = tgt; i_flush = fl;
    #1;
    chk_model("cyc");
    @(posedge clk);
    m_apply(u, int'(upc), tk, int'(tgt), fl);
    @(negedge clk);
    i_upd = 1'b0; i_flush = 1'b0;
  endtask

  task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
    cycle(16'h0000, 1'b1, pc, tk, tgt, 1'b0);
  endtask

  // Read with explicit constant expectations
  task automatic expect_rd(input string nm, input logic [15:0] pc, input logic eh,
                           input logic et, input logic [15:0] etg);
    i_rd_pc = pc; i_upd = 1'b0; i_flush = 1'b0;
    #1;
    chk({nm, "_hit"}, 32'(o_hit), 32'(eh));
    chk({nm, "_taken"}, 32'(o_taken), 32'(et));
    chk({nm, "_target"}, 32'(o_target), 32'(etg));
    $display("%s pc=%04h hit=%0b taken=%0b target=%04h", nm, pc, o_hit, o_taken, o_target);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; i_flush = 1'b0; i_rd_pc = '0; i_upd = 1'b0;
    i_upd_pc = '0; i_upd_taken = 1'b0; i_upd_target = '0;
    m_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    expect_rd("reset", 16'h0012, 0, 0, 16'h0000);

    upd(16'h0012, 1, 16'h0040);
    expect_rd("alloc", 16'h0012, 1, 1, 16'h0040);
    expect_rd("tagdiff", 16'h0112, 0, 0, 16'h0000);

    upd(16'h0012, 0, 16'h0000);
    upd(16'h0012, 0, 16'h0000);
    expect_rd("ctr0", 16'h0012, 1, 0, 16'h0040);
    upd(16'h0012, 0, 16'h0000);
    expect_rd("ctr0sat", 16'h0012, 1, 0, 16'h0040);
    upd(16'h0012, 1, 16'h0040);
    upd(16'h0012, 1, 16'h0040);
    upd(16'h0012, 1, 16'h0040);
    expect_rd("ctr3", 16'h0012, 1, 1, 16'h0040);
    upd(16'h0012, 1, 16'h0050);
    expect_rd("newtgt", 16'h0012, 1, 1, 16'h0050);
    upd(16'h0012, 0, 16'h0000);
    expect_rd("ctr3sat", 16'h0012, 1, 1, 16'h0050);

    upd(16'h0112, 1, 16'h0060);
    upd(16'h0212, 1, 16'h0070);
    expect_rd("evict0", 16'h0012, 0, 0, 16'h0000);
    expect_rd("keep1", 16'h0112, 1, 1, 16'h0060);
    expect_rd("new0", 16'h0212, 1, 1, 16'h0070);
    upd(16'h0312, 1, 16'h0080);
    expect_rd("evict1", 16'h0112, 0, 0, 16'h0000);
    expect_rd("new1", 16'h0312, 1, 1, 16'h0080);
    expect_rd("keep0", 16'h0212, 1, 1, 16'h0070);

    upd(16'h0033, 0, 16'h0099);
    expect_rd("ntmiss", 16'h0033, 0, 0, 16'h0000);

    // Same-cycle read of the PC being allocated sees the old (empty) set
    cycle(16'h0055, 1'b1, 16'h0055, 1'b1, 16'h1234, 1'b0);
    expect_rd("bypass", 16'h0055, 1, 1, 16'h1234);

    cycle(16'h0000, 1'b1, 16'h0044, 1'b1, 16'h0400, 1'b1);
    expect_rd("flush44", 16'h0044, 0, 0, 16'h0000);
    expect_rd("flush212", 16'h0212, 0, 0, 16'h0000);
    expect_rd("flush55", 16'h0055, 0, 0, 16'h0000);

    // Randomized traffic over two sets and six tags to force conflicts
    for (int i = 0; i < 400; i++) begin
      logic [15:0] rpc, upc, tgt;
      logic u, tk, fl;
      rpc = {5'h0, 3'($urandom_range(0, 5)), 7'h09, 1'($urandom_range(0, 1))};
      upc = {5'h0, 3'($urandom_range(0, 5)), 7'h09, 1'($urandom_range(0, 1))};
      tgt = 16'($urandom);
      u   = ($urandom_range(0, 3) != 0);
      tk  = ($urandom_range(0, 9) < 6);
      fl  = ($urandom_range(0, 49) == 0);
      cycle(rpc, u, upc, tk, tgt, fl);
    end

    // Asynchronous reset drops a live hit without any clock edge
    upd(16'h0077, 1, 16'h0099);
    i_rd_pc = 16'h0077;
    #1;
    chk("prereset_hit", 32'(o_hit), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_hit", 32'(o_hit), 32'h0);
    chk("async_rst_target", 32'(o_target), 32'h0);
    $display("async reset pc=0077 hit=%0b target=%04h", o_hit, o_target);
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    expect_rd("postreset", 16'h0077, 0, 0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard stop in case something stalls the sequence
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
